// File: rtl/aes_word_stream_adapter.sv
// aes_word_stream_adapter: packs four 32-bit stream words into an AES
// block, drives one core transaction, and streams the result back out.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   s_data/s_valid/s_ready   upstream word stream (word 0 = bits 127:96)
//   key_in              AES key, captured when the start pulse is issued
//   m_data/m_valid/m_ready   downstream word stream (word 0 = bits 127:96)
//   aes_start/aes_plaintext/aes_key   request side of the AES core
//   aes_ciphertext/aes_valid/aes_busy/aes_fault   response side of the core
//   clear_err           clears err_fault and err_timeout
//   err_fault/err_timeout    sticky error flags
//   blk_count           number of blocks fully drained (wraps)
module aes_word_stream_adapter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  s_data,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] key_in,
  output logic [31:0]  m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         aes_start,
  output logic [127:0] aes_plaintext,
  output logic [127:0] aes_key,
  input  logic [127:0] aes_ciphertext,
  input  logic         aes_valid,
  input  logic         aes_busy,
  input  logic         aes_fault,
  input  logic         clear_err,
  output logic         err_fault,
  output logic         err_timeout,
  output logic [15:0]  blk_count
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [15:0] LP_TLAST = 16'(TIMEOUT_CYCLES - 1);

  state_t       r_state;
  logic [1:0]   r_wcnt;
  logic [1:0]   r_idx;
  logic [15:0]  r_timer;
  logic [127:0] r_pt;
  logic [127:0] r_key;
  logic [127:0] r_ct;
  logic         r_start;
  logic         r_mvalid;
  logic         r_err_fault;
  logic         r_err_timeout;
  logic [15:0]  r_blk;

  logic         w_s_ready;
  logic         w_accept;
  logic         w_xfer;
  logic [31:0]  w_m_data;

  // Gated by rst so the upstream sees no ready while reset is held,
  // even though the state register already sits in FILL.
  assign w_s_ready = (r_state == FILL) & ~rst;
  assign w_accept  = s_valid & w_s_ready;
  assign w_xfer    = r_mvalid & m_ready;

  always_comb begin
    w_m_data = r_ct[127:96];
    unique case (r_idx)
      2'd0: w_m_data = r_ct[127:96];
      2'd1: w_m_data = r_ct[95:64];
      2'd2: w_m_data = r_ct[63:32];
      2'd3: w_m_data = r_ct[31:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= FILL;
      r_wcnt        <= 2'd0;
      r_idx         <= 2'd0;
      r_timer       <= 16'd0;
      r_pt          <= '0;
      r_key         <= '0;
      r_ct          <= '0;
      r_start       <= 1'b0;
      r_mvalid      <= 1'b0;
      r_err_fault   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_blk         <= 16'd0;
    end else begin
      r_start <= 1'b0;
      // Set events below are written later, so they win over clear.
      if (clear_err) begin
        r_err_fault   <= 1'b0;
        r_err_timeout <= 1'b0;
      end
      unique case (r_state)
        FILL: begin
          if (w_accept) begin
            r_pt   <= {r_pt[95:0], s_data};
            r_wcnt <= r_wcnt + 2'd1;
            if (r_wcnt == 2'd3) begin
              r_state <= ISSUE;
              // Issue the start during the first ISSUE cycle when
              // the core is already idle, saving a cycle.
              if (!aes_busy) begin
                r_start <= 1'b1;
                r_key   <= key_in;
              end
            end
          end
        end
        ISSUE: begin
          r_timer <= 16'd0;
          if (r_start) begin
            r_state <= WAIT;
          end else if (!aes_busy) begin
            r_start <= 1'b1;
            r_key   <= key_in;
          end
        end
        WAIT: begin
          if (aes_fault) begin
            r_err_fault <= 1'b1;
            r_wcnt      <= 2'd0;
            r_state     <= FILL;
          end else if (aes_valid) begin
            r_ct     <= aes_ciphertext;
            r_idx    <= 2'd0;
            r_mvalid <= 1'b1;
            r_state  <= DRAIN;
          end else if (r_timer == LP_TLAST) begin
            r_err_timeout <= 1'b1;
            r_wcnt        <= 2'd0;
            r_state       <= FILL;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        DRAIN: begin
          if (w_xfer) begin
            if (r_idx == 2'd3) begin
              r_idx    <= 2'd0;
              r_mvalid <= 1'b0;
              r_blk    <= r_blk + 16'd1;
              r_state  <= FILL;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign s_ready       = w_s_ready;
  assign m_data        = w_m_data;
  assign m_valid       = r_mvalid;
  assign aes_start     = r_start;
  assign aes_plaintext = r_pt;
  assign aes_key       = r_key;
  assign err_fault     = r_err_fault;
  assign err_timeout   = r_err_timeout;
  assign blk_count     = r_blk;

endmodule
